// File: rtl/ariane_pkg.sv
// ariane_pkg: minimal fetch entry types shared by the frontend and decode stage.
package ariane_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } exception_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
        exception_t  ex;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_queue.sv
// fetch_entry_queue: FIFO of fetch entries between frontend and decode, blocks enqueue after an exception entry.
module fetch_entry_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  ariane_pkg::fetch_entry_t   fetch_entry_i,
    input  logic                       fetch_entry_valid_i,
    output logic                       fetch_entry_ready_o,
    output ariane_pkg::fetch_entry_t   fetch_entry_o,
    output logic                       fetch_entry_valid_o,
    input  logic                       fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]     usage_o,
    output logic                       ex_blocked_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    ariane_pkg::fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          blocked, push, pop;

    assign fetch_entry_ready_o = (count < FULL) && !blocked && !flush_i;
    assign fetch_entry_valid_o = (count != '0) && !flush_i;
    assign fetch_entry_o       = mem[rd_ptr];
    assign usage_o             = count;
    assign ex_blocked_o        = blocked;
    assign push                = fetch_entry_valid_i && fetch_entry_ready_o;
    assign pop                 = fetch_entry_valid_o && fetch_entry_ready_i;

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= fetch_entry_i;
    end

    // Flush shares reset's effect on all control state; storage is left as-is.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            blocked <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count   <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            blocked <= blocked || (push && fetch_entry_i.ex.valid);
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && count == FULL));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && count == '0));
    a_usage_range:  assert property (@(posedge clk_i) disable iff (rst_i) usage_o <= FULL);

endmodule

// File: tb/tb_fetch_entry_queue.sv
// tb_fetch_entry_queue: directed plan plus random traffic checked against a queue-based reference model.
module tb_fetch_entry_queue;
    import ariane_pkg::*;

    localparam int DEPTH = 4;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               flush_i = 1'b0;
    fetch_entry_t       fetch_entry_i = '0;
    logic               fetch_entry_valid_i = 1'b0;
    logic               fetch_entry_ready_o;
    fetch_entry_t       fetch_entry_o;
    logic               fetch_entry_valid_o;
    logic               fetch_entry_ready_i = 1'b0;
    logic [2:0]         usage_o;
    logic               ex_blocked_o;

    fetch_entry_queue #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .usage_o             (usage_o),
        .ex_blocked_o        (ex_blocked_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    fetch_entry_t mq[$];
    bit mblk = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [31:0] addr, input bit exv);
        fetch_entry_t e;
        e.address     = addr;
        e.instruction = $urandom;
        e.ex.valid    = exv;
        e.ex.cause    = exv ? 4'($urandom_range(15)) : 4'd0;
        return e;
    endfunction

    // Drive one cycle, check outputs against the model, then advance the model across the edge.
    task automatic step(input bit v, input fetch_entry_t e, input bit r, input bit f, input bit rs);
        bit exp_rdy, exp_val;
        @(negedge clk_i);
        fetch_entry_valid_i = v;
        fetch_entry_i       = e;
        fetch_entry_ready_i = r;
        flush_i             = f;
        rst_i               = rs;
        #1;
        exp_rdy = (mq.size() < DEPTH) && !mblk && !f;
        exp_val = (mq.size() != 0) && !f;
        check("ready_o", 128'(fetch_entry_ready_o), 128'(exp_rdy));
        check("valid_o", 128'(fetch_entry_valid_o), 128'(exp_val));
        check("usage_o", 128'(usage_o), 128'(mq.size()));
        check("ex_blocked_o", 128'(ex_blocked_o), 128'(mblk));
        if (exp_val)
            check("head", 128'(fetch_entry_o), 128'(mq[0]));
        @(posedge clk_i);
        if (rs || f) begin
            mq.delete();
            mblk = 0;
        end else begin
            if (exp_val && r)
                void'(mq.pop_front());
            if (exp_rdy && v) begin
                mq.push_back(e);
                if (e.ex.valid)
                    mblk = 1;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        // reset state, then push A,B,C with decode stalled
        step(0, '0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, mk(32'h100 + 32'(k), 0), 0, 0, 0);
        step(0, '0, 0, 0, 0);
        // fill to DEPTH, then pop while frontend still offers
        step(1, mk(32'h200, 0), 0, 0, 0);
        step(1, mk(32'h204, 0), 0, 0, 0);
        step(1, mk(32'h208, 0), 1, 0, 0);
        step(0, '0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, '0, 1, 0, 0);
        // steady streaming
        for (int k = 0; k < 20; k++) step(1, mk(32'h8000_0000 + 32'(4 * k), 0), 1, 0, 0);
        for (int k = 0; k < 2; k++) step(0, '0, 1, 0, 0);
        // exception block
        step(1, mk(32'h300, 1), 0, 0, 0);
        step(1, mk(32'h304, 0), 0, 0, 0);
        step(1, mk(32'h308, 0), 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, mk(32'h30c, 0), 1, 0, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 0, 0);
        // flush with three buffered and both handshakes offered
        for (int k = 0; k < 3; k++) step(1, mk(32'h400 + 32'(k), 0), 0, 0, 0);
        step(1, mk(32'h4ff, 0), 1, 1, 0);
        step(0, '0, 0, 0, 0);
        // reset mid-stream, then wrap the pointers
        for (int k = 0; k < 2; k++) step(1, mk(32'h500 + 32'(k), 0), 0, 0, 0);
        step(1, mk(32'h5ff, 0), 1, 0, 1);
        step(0, '0, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            step(1, mk(32'h600 + 32'(k), 0), 0, 0, 0);
            step(0, '0, 1, 0, 0);
        end
        // random traffic
        for (int k = 0; k < 3000; k++)
            step($urandom_range(3) != 0, mk($urandom, $urandom_range(40) == 0),
                 $urandom_range(2) != 0, $urandom_range(30) == 0, $urandom_range(300) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
